soc_system_avmm_cmd_master: RTL
===============================

# soc_system_avmm_cmd_master

- Avalon-MM initiator that turns single commands from a valid/ready command port into bus transactions on PIO-style register responders (address, chipselect, write_n, writedata, readdata).
- Returns one response per command: read data, or a write acknowledge.
- Sits between a control sequencer/FSM in the fabric and the 32-bit PIO register slaves of the soc_system interconnect.
- Strictly one transaction outstanding.

## Interface
Parameters:
- ADDR_W, 2, width of responder word address
- DATA_W, 32, data width
- RD_LATENCY, 1, cycles from chipselect cycle to readdata valid at the responder output (legal 1..4)
- TIMEOUT, 255, max waitrequest cycles before abort (only with macro)

Ports:
- clk  in  1  single clock; all logic rising-edge
- reset  in  1  asynchronous, active-high; clears all state immediately
- cmd_valid  in  1  command present
- cmd_ready  out  1  block can accept (registered)
- cmd_write  in  1  1 = write, 0 = read
- cmd_address  in  ADDR_W  target address
- cmd_writedata  in  DATA_W  write data
- rsp_valid  out  1  response present; held until rsp_ready
- rsp_ready  in  1  consumer accepts response
- rsp_write  out  1  echo of cmd_write
- rsp_readdata  out  DATA_W  read data; 0 for writes
- rsp_error  out  1  timeout abort (constant 0 without macro)
- av_address  out  ADDR_W  bus address
- av_chipselect  out  1  bus select
- av_write_n  out  1  active-low write strobe
- av_writedata  out  DATA_W  bus write data
- av_readdata  in  DATA_W  bus read data
- av_waitrequest  in  1  responder stall (port exists only with macro)

## Operation
- States:
  - IDLE: cmd_ready=1.
  - ISSUE: chipselect=1.
  - WAIT: read only; counts RD_LATENCY cycles.
  - RESP: rsp_valid=1.
- Transitions:
  - IDLE -> ISSUE on cmd_valid && cmd_ready. Command fields are captured into registers at the same edge.
  - ISSUE -> WAIT (read) or RESP (write) after one cycle, or when waitrequest is low (with macro).
  - WAIT -> RESP after RD_LATENCY cycles. av_readdata is sampled at the last WAIT edge.
  - RESP -> IDLE on rsp_ready.
- Bus outputs are registered and driven only in ISSUE. In every other state: chipselect=0, write_n=1, address=0, writedata=0.
- In ISSUE, av_write_n = ~cmd_write. Address and writedata are held stable for the whole ISSUE duration.
- Response fields are registered and stay stable while rsp_valid=1 and rsp_ready=0.
- cmd_valid is ignored outside IDLE; cmd_ready is low there.
- Reset values: cmd_ready=0, rsp_valid=0, rsp_write=0, rsp_readdata=0, rsp_error=0, av_chipselect=0, av_write_n=1, av_address=0, av_writedata=0. State is IDLE.
- Reset mid-transaction: the bus cycle is abandoned and chipselect drops asynchronously. Any pending response is discarded with no replay.

## Timing
- Command accepted at edge k. ISSUE occupies cycle k+1.
- Write: rsp_valid rises in cycle k+2.
- Read, no stall: readdata is sampled at the end of cycle k+1+RD_LATENCY; rsp_valid rises in cycle k+2+RD_LATENCY.
  - RD_LATENCY=1 gives rsp_valid in cycle k+3.
- Each waitrequest-high cycle in ISSUE adds one cycle to every figure above.
- Back-to-back: with rsp_ready held high, cmd_ready returns one cycle after rsp_valid. Minimum spacing between accepts: 3 cycles for writes, 3+RD_LATENCY cycles for reads.
- cmd_ready goes high at the first clock edge after reset deasserts.

## Configuration
- SOC_AVMM_CMD_MASTER_WAITREQ_EN defined:
  - The av_waitrequest port exists, and ISSUE holds while it is high.
  - A stall counter increments on each waitrequest-high cycle. When it reaches TIMEOUT, the block drops chipselect and goes to RESP with rsp_error=1 and rsp_readdata=0.
  - The counter clears on entry to ISSUE.
- Not defined:
  - The av_waitrequest port is absent and ISSUE is exactly one cycle.
  - rsp_error is tied to 0 and the counter logic is omitted.

## Test plan
- Reset release, then write cmd (addr 0, data 0xDEADBEEF):
  - av_chipselect=1 and av_write_n=0 for exactly one cycle, with address 0 and writedata 0xDEADBEEF.
  - rsp_valid at k+2 with rsp_write=1 and rsp_readdata=0.
- Read cmd (addr 0) with av_readdata=0x12345678 and RD_LATENCY=1:
  - rsp_valid at k+3 with rsp_readdata=0x12345678 and rsp_error=0.
- Backpressure: rsp_ready held 0 for 5 cycles.
  - Response stays stable, cmd_ready stays 0, and a cmd_valid pulse during this window is ignored (no extra bus cycle).
- Reset asserted during ISSUE:
  - av_chipselect drops with no clock edge needed.
  - After release, no rsp_valid appears and cmd_ready=1 at the first edge.
- Macro defined, waitrequest high for 3 cycles on a read:
  - ISSUE lasts 4 cycles with stable address, and rsp_valid arrives 3 cycles later than the no-stall case.
- Macro defined, TIMEOUT=4, waitrequest stuck high:
  - Abort after 4 stall cycles; rsp_error=1, rsp_readdata=0; cmd_ready=1 after the response is accepted.

Source files
------------

// File: rtl/soc_system_avmm_cmd_master.sv
`default_nettype none
// ============================================================================
// Module      : soc_system_avmm_cmd_master
// Description : Avalon-MM initiator for PIO-style register responders.
//               It accepts one command at a time on a valid/ready port,
//               runs a single bus cycle, and returns one response (read
//               data or a write acknowledge). Only one transaction is ever
//               outstanding.
// Ports       : clk, reset (async, active-high)
//               cmd_valid/cmd_ready/cmd_write/cmd_address/cmd_writedata
//                   - command port; cmd_ready is registered
//               rsp_valid/rsp_ready/rsp_write/rsp_readdata/rsp_error
//                   - response port; fields are held until rsp_ready
//               av_address/av_chipselect/av_write_n/av_writedata/
//               av_readdata[/av_waitrequest]
//                   - Avalon-MM bus; outputs are registered
// Macro       : SOC_AVMM_CMD_MASTER_WAITREQ_EN adds av_waitrequest, stall
//               handling and a TIMEOUT abort that reports rsp_error=1.
// Revision    : 1.0 - initial release
// ============================================================================
module soc_system_avmm_cmd_master #(
    parameter int ADDR_W     = 2,
    parameter int DATA_W     = 32,
    parameter int RD_LATENCY = 1,
    parameter int TIMEOUT    = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_address,
    input  logic [DATA_W-1:0] cmd_writedata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_write,
    output logic [DATA_W-1:0] rsp_readdata,
    output logic              rsp_error,
    output logic [ADDR_W-1:0] av_address,
    output logic              av_chipselect,
    output logic              av_write_n,
    output logic [DATA_W-1:0] av_writedata,
`ifdef SOC_AVMM_CMD_MASTER_WAITREQ_EN
    input  logic              av_waitrequest,
`endif
    input  logic [DATA_W-1:0] av_readdata
);

    localparam int LAT_W = 3;

    generate
        if (RD_LATENCY < 1 || RD_LATENCY > 4) begin : g_bad_rd_latency
            $error("RD_LATENCY must be within 1..4");
        end
        if (TIMEOUT < 1) begin : g_bad_timeout
            $error("TIMEOUT must be at least 1");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_next_state;
    logic                w_enter_resp;
    logic                r_cmd_ready;
    logic                r_write;
    logic [LAT_W-1:0]    r_lat_cnt;
    logic                r_rsp_valid;
    logic                r_rsp_write;
    logic [DATA_W-1:0]   r_rsp_readdata;
    logic [ADDR_W-1:0]   r_av_address;
    logic                r_av_chipselect;
    logic                r_av_write_n;
    logic [DATA_W-1:0]   r_av_writedata;

`ifdef SOC_AVMM_CMD_MASTER_WAITREQ_EN
    localparam int STALL_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    logic                w_abort;
    logic                r_rsp_error;
    logic [STALL_W-1:0]  r_stall_cnt;
`endif

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
`ifdef SOC_AVMM_CMD_MASTER_WAITREQ_EN
        w_abort      = 1'b0;
`endif
        case (r_state)
            S_IDLE: begin
                if (cmd_valid && r_cmd_ready) begin
                    w_next_state = S_ISSUE;
                end
            end
            S_ISSUE: begin
`ifdef SOC_AVMM_CMD_MASTER_WAITREQ_EN
                if (!av_waitrequest) begin
                    w_next_state = r_write ? S_RESP : S_WAIT;
                end else if (r_stall_cnt == STALL_W'(TIMEOUT - 1)) begin
                    // This is the TIMEOUT-th stalled cycle: give up.
                    w_next_state = S_RESP;
                    w_abort      = 1'b1;
                end
`else
                w_next_state = r_write ? S_RESP : S_WAIT;
`endif
            end
            S_WAIT: begin
                if (r_lat_cnt == LAT_W'(RD_LATENCY - 1)) begin
                    w_next_state = S_RESP;
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    w_next_state = S_IDLE;
                end
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    assign w_enter_resp = (r_state != S_RESP) && (w_next_state == S_RESP);

    // ------------------------------------------------------------------
    // Datapath, bus and response registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cmd_ready     <= 1'b0;
            r_write         <= 1'b0;
            r_lat_cnt       <= '0;
            r_rsp_valid     <= 1'b0;
            r_rsp_write     <= 1'b0;
            r_rsp_readdata  <= '0;
            r_av_address    <= '0;
            r_av_chipselect <= 1'b0;
            r_av_write_n    <= 1'b1;
            r_av_writedata  <= '0;
        end else begin
            // Registered ready: high in every cycle spent in IDLE, which
            // also makes it rise at the first edge after reset release.
            r_cmd_ready <= (w_next_state == S_IDLE);

            // The bus registers double as the command capture for address
            // and write data; they simply hold while ISSUE is extended.
            if (r_state == S_IDLE && w_next_state == S_ISSUE) begin
                r_write         <= cmd_write;
                r_av_address    <= cmd_address;
                r_av_chipselect <= 1'b1;
                r_av_write_n    <= ~cmd_write;
                r_av_writedata  <= cmd_writedata;
            end else if (w_next_state != S_ISSUE) begin
                r_av_address    <= '0;
                r_av_chipselect <= 1'b0;
                r_av_write_n    <= 1'b1;
                r_av_writedata  <= '0;
            end

            if (r_state == S_WAIT) begin
                r_lat_cnt <= r_lat_cnt + LAT_W'(1);
            end else begin
                r_lat_cnt <= '0;
            end

            if (w_enter_resp) begin
                r_rsp_valid    <= 1'b1;
                r_rsp_write    <= r_write;
                // Only a completed read returns bus data; writes and
                // aborts (both leave from ISSUE) return zero.
                r_rsp_readdata <= (r_state == S_WAIT) ? av_readdata : '0;
            end else if (r_state == S_RESP && rsp_ready) begin
                r_rsp_valid    <= 1'b0;
            end
        end
    end

`ifdef SOC_AVMM_CMD_MASTER_WAITREQ_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_stall_cnt <= '0;
            r_rsp_error <= 1'b0;
        end else begin
            if (r_state == S_IDLE) begin
                r_stall_cnt <= '0;
            end else if (r_state == S_ISSUE && av_waitrequest) begin
                r_stall_cnt <= r_stall_cnt + STALL_W'(1);
            end
            if (w_enter_resp) begin
                r_rsp_error <= w_abort;
            end
        end
    end

    assign rsp_error = r_rsp_error;
`else
    assign rsp_error = 1'b0;
`endif

    assign cmd_ready     = r_cmd_ready;
    assign rsp_valid     = r_rsp_valid;
    assign rsp_write     = r_rsp_write;
    assign rsp_readdata  = r_rsp_readdata;
    assign av_address    = r_av_address;
    assign av_chipselect = r_av_chipselect;
    assign av_write_n    = r_av_write_n;
    assign av_writedata  = r_av_writedata;

endmodule
`default_nettype wire
